logic_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's 1-bit combinational gate block.
- Applies one of eight bitwise logic functions to two WIDTH-bit operands, selected per transaction by an opcode.
- Two register stages with valid/ready handshakes at input and output.
- Saturating count of completed transactions.
- Used as a generic bitwise-logic engine between streaming producers and consumers.

---
 rtl/logic_unit_pipe.sv | 176 +++++++++++++++++
 tb/tb_logic_unit_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic engine with valid/ready
// handshakes at both ends and a saturating count of delivered results.
//
// Optional feature macro: LOGIC_FLAGS_EN
//   When defined, res_parity and res_ones are added. They are registered in
//   stage 2 alongside out_res.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   in_a, in_b, in_op     operands and function select
//   out_valid / out_ready output handshake
//   out_res, out_zero     result and zero flag
//   out_op                opcode that produced out_res
//   txn_count             delivered results, saturating
//   res_parity, res_ones  result parity and popcount (LOGIC_FLAGS_EN only)
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic [2:0]       out_op,
  output logic [CNT_W-1:0] txn_count
`ifdef LOGIC_FLAGS_EN
  ,
  output logic                         res_parity,
  output logic [$clog2(WIDTH+1)-1:0]   res_ones
`endif
);

  localparam int unsigned ONES_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_NOT_A = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_NOR   = 3'd4;
  localparam logic [2:0] OP_NAND  = 3'd5;
  localparam logic [2:0] OP_XNOR  = 3'd6;
  localparam logic [2:0] OP_PASS  = 3'd7;

  // Stage 1 registers
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_op;

  // Stage 2 (output) registers
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_res;
  logic             r_out_zero;
  logic [2:0]       r_out_op;
  logic [CNT_W-1:0] r_txn_count;

  logic             w_adv2;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [WIDTH-1:0] w_res;
  logic [ONES_W-1:0] w_ones;

  // Stage 2 can take stage 1's contents when its own slot is empty or draining
  assign w_adv2     = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready   = !r_s1_valid || w_adv2;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  // Function evaluation, stage 2 only
  always_comb begin
    w_res = '0;
    case (r_s1_op)
      OP_NOT_A: w_res = ~r_s1_a;
      OP_OR:    w_res = r_s1_a | r_s1_b;
      OP_AND:   w_res = r_s1_a & r_s1_b;
      OP_XOR:   w_res = r_s1_a ^ r_s1_b;
      OP_NOR:   w_res = ~(r_s1_a | r_s1_b);
      OP_NAND:  w_res = ~(r_s1_a & r_s1_b);
      OP_XNOR:  w_res = ~(r_s1_a ^ r_s1_b);
      OP_PASS:  w_res = r_s1_a;
      default:  w_res = '0;
    endcase
  end

  // Popcount of the stage-2 input result
  always_comb begin
    w_ones = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_ones = w_ones + ONES_W'(w_res[i]);
    end
  end

  // Stage 1: capture on input transfer, empty when it advances without refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_a     <= in_a;
        r_s1_b     <= in_b;
        r_s1_op    <= in_op;
      end else if (w_adv2) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: load on advance, drop valid on a bubble, hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_res   <= '0;
      r_out_zero  <= 1'b1;
      r_out_op    <= '0;
    end else begin
      if (w_adv2) begin
        r_out_valid <= 1'b1;
        r_out_res   <= w_res;
        r_out_zero  <= (w_res == '0);
        r_out_op    <= r_s1_op;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Delivered-result counter, sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txn_count <= '0;
    end else if (w_out_fire && (r_txn_count != '1)) begin
      r_txn_count <= r_txn_count + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_res   = r_out_res;
  assign out_zero  = r_out_zero;
  assign out_op    = r_out_op;
  assign txn_count = r_txn_count;

`ifdef LOGIC_FLAGS_EN
  logic              r_res_parity;
  logic [ONES_W-1:0] r_res_ones;

  // Flags follow out_res exactly, including hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_parity <= 1'b0;
      r_res_ones   <= '0;
    end else if (w_adv2) begin
      r_res_parity <= ^w_res;
      r_res_ones   <= w_ones;
    end
  end

  assign res_parity = r_res_parity;
  assign res_ones   = r_res_ones;
`else
  logic w_unused_ones;
  assign w_unused_ones = ^w_ones;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed + random stimulus against a queue-based
// reference model of logic_unit_pipe (WIDTH=8, CNT_W=4).
module tb_logic_unit_pipe;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ONES_W = $clog2(WIDTH + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_zero;
  logic [2:0]       out_op;
  logic [CNT_W-1:0] txn_count;
`ifdef LOGIC_FLAGS_EN
  logic              res_parity;
  logic [ONES_W-1:0] res_ones;
`endif

  logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_zero  (out_zero),
    .out_op    (out_op),
    .txn_count (txn_count)
`ifdef LOGIC_FLAGS_EN
    ,
    .res_parity(res_parity),
    .res_ones  (res_ones)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [2:0]       op;
    int               stamp;
  } item_t;

  item_t q[$];
  int    model_cnt = 0;
  int    total = 0;
  int    bad = 0;

  function automatic logic [WIDTH-1:0] ref_fn(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      3'd0: return ~a;
      3'd1: return a | b;
      3'd2: return a & b;
      3'd3: return a ^ b;
      3'd4: return ~(a | b);
      3'd5: return ~(a & b);
      3'd6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, check against the model, advance the model
  task automatic cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [2:0] op, input logic ordy, output logic acc);
    logic exp_rdy;
    logic exp_v;
    logic deliver;
    int   now;
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = ordy;
    #1;
    now     = cyc;
    exp_rdy = (q.size() < 2) || ordy;
    exp_v   = (q.size() > 0) && (now >= q[0].stamp + 1);
    check("txn_count", 32'(txn_count), 32'(model_cnt));
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(exp_v));
    if (exp_v) begin
      check("out_res", 32'(out_res), 32'(q[0].res));
      check("out_op", 32'(out_op), 32'(q[0].op));
      check("out_zero", 32'(out_zero), 32'(q[0].res == '0));
`ifdef LOGIC_FLAGS_EN
      check("res_parity", 32'(res_parity), 32'(^q[0].res));
      check("res_ones", 32'(res_ones), 32'($countones(q[0].res)));
`endif
    end
    acc     = v && exp_rdy;
    deliver = exp_v && ordy;
    @(posedge clk);
    if (deliver) begin
      void'(q.pop_front());
      if (model_cnt < (2 ** CNT_W) - 1) model_cnt++;
    end
    if (acc) q.push_back('{res: ref_fn(op, a, b), op: op, stamp: now + 1});
  endtask

  logic             acc;
  logic [WIDTH-1:0] ha;
  logic [WIDTH-1:0] hb;
  logic [2:0]       hop;
  int               sent;

  task automatic idle(input int n);
    logic a_unused;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 3'd0, 1'b1, a_unused);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_res", 32'(out_res), 32'd0);
    check("rst out_op", 32'(out_op), 32'd0);
    check("rst out_zero", 32'(out_zero), 32'd1);
    check("rst txn_count", 32'(txn_count), 32'd0);
`ifdef LOGIC_FLAGS_EN
    check("rst res_parity", 32'(res_parity), 32'd0);
    check("rst res_ones", 32'(res_ones), 32'd0);
`endif
    q.delete();
    model_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-rst in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("init out_valid", 32'(out_valid), 32'd0);
    check("init out_zero", 32'(out_zero), 32'd1);
    check("init txn_count", 32'(txn_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("init in_ready", 32'(in_ready), 32'd1);

    // Every opcode on C5/3A
    for (int op = 0; op < 8; op++) cycle(1'b1, 8'hC5, 8'h3A, 3'(op), 1'b1, acc);
    idle(4);

    // 16 back-to-back transfers from a clean counter: saturation at 15
    pulse_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b1, acc);
    idle(4);
    check("txn_count saturated", 32'(txn_count), 32'd15);

    // Three transfers into a stalled consumer, then release
    sent = 0;
    ha = 8'($urandom); hb = 8'($urandom); hop = 3'($urandom);
    for (int k = 0; k < 12; k++) begin
      cycle(sent < 3, ha, hb, hop, k >= 5, acc);
      if (acc) begin
        sent++;
        ha = 8'($urandom); hb = 8'($urandom); hop = 3'($urandom);
      end
    end
    check("stall sent", 32'(sent), 32'd3);
    idle(3);

    // Alternating out_ready with continuous in_valid
    pulse_reset();
    for (int k = 0; k < 40; k++) begin
      cycle(1'b1, ha, hb, hop, k[0], acc);
      if (acc) begin
        ha = 8'($urandom); hb = 8'($urandom); hop = 3'($urandom);
      end
    end
    idle(4);

    // Reset while two transactions are in flight; nothing stale afterwards
    cycle(1'b1, 8'h12, 8'h34, 3'd3, 1'b0, acc);
    cycle(1'b1, 8'h56, 8'h78, 3'd1, 1'b0, acc);
    pulse_reset();
    idle(4);

    // Flag cases
    cycle(1'b1, 8'hF0, 8'h0F, 3'd1, 1'b1, acc);
    cycle(1'b1, 8'h01, 8'h00, 3'd7, 1'b1, acc);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound in case something stalls the sequence
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
